uart_word_serializer: RTL and testbench
=======================================

# uart_word_serializer

Upstream feeder for the UART transmitter. Accepts a wide word (e.g. a ciphertext or tally limb) over a valid/ready handshake and emits it one byte at a time, LSB byte first, as single-cycle triggers into the transmitter. It paces itself on the transmitter's busy flag, so no byte is ever issued while a frame is in flight.

## Interface
- WORD_WIDTH, 64: input word width in bits. Must be a multiple of 8 and at least 8; any other value is an elaboration-time error.
- HEADER_BYTE, 8'hA5: sync byte; used only when the header feature is compiled in.
- clk_in  input  1  system clock (100 MHz).
- rst_n_in  input  1  reset. Asynchronous assert, active-low.
- word_in  input  WORD_WIDTH  word to send. Sampled when word_valid_in && word_ready_out.
- word_valid_in  input  1  word_in is valid.
- word_ready_out  output  1  serializer can accept a word. High only in IDLE.
- tx_busy_in  input  1  transmitter busy flag. Rises one cycle after a trigger and stays high until the stop bit ends.
- tx_byte_out  output  8  byte to transmit; equals shift_reg[7:0].
- tx_trigger_out  output  1  one-cycle start pulse to the transmitter.
- busy_out  output  1  high whenever state != IDLE.

## Operation
- NUM_BYTES = WORD_WIDTH/8.
- Internal state:
  - shift register shift_reg (WORD_WIDTH bits).
  - byte counter bytes_left, $clog2(NUM_BYTES+2) bits.
  - FSM with states IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE:
  - word_ready_out=1.
  - On valid&&ready: shift_reg<=word_in, bytes_left<=NUM_BYTES, go to SEND.
- SEND:
  - tx_trigger_out = !tx_busy_in (combinational).
  - If tx_busy_in=0: go to WAIT_HI. Otherwise hold in SEND with no trigger.
- WAIT_HI:
  - Wait for tx_busy_in=1, then go to WAIT_LO.
  - Exists so the serializer never re-triggers during the one-cycle lag of the transmitter's registered busy flag.
  - No timeout; it waits indefinitely.
- WAIT_LO: wait for tx_busy_in=0, then:
  - bytes_left==1: go to IDLE.
  - otherwise: shift_reg <= shift_reg >> 8 (zero fill), bytes_left <= bytes_left-1, go to SEND.
- Exactly one trigger is issued per byte, so a word produces exactly NUM_BYTES triggers (NUM_BYTES+1 with the header).
- word_in changing while busy has no effect.

## Timing
- Reset values:
  - state=IDLE, shift_reg=0, bytes_left=0.
  - word_ready_out=1, tx_trigger_out=0, tx_byte_out=8'h00, busy_out=0.
- Accept at edge t. SEND during cycle t+1, so the first trigger is in cycle t+1 if the transmitter is idle.
- Trigger in cycle c:
  - busy is expected high in cycle c+1.
  - The FSM is in WAIT_LO from c+2.
- Busy first observed low in cycle d. Next trigger is in cycle d+1, so there is one idle cycle between frames.
- After the last byte's busy falls at cycle d:
  - word_ready_out=1 in cycle d+1.
  - The next word can be accepted at the d+1 edge.
- tx_busy_in high on entry to SEND (shared or still-busy transmitter): the trigger is stalled and tx_byte_out is held stable.
- Asynchronous reset mid-word:
  - Immediate return to IDLE; the partial word is dropped with no further triggers.
  - The transmitter finishes any in-flight byte independently.
- Back-to-back words: no overlap. The next word is accepted only after the final byte completes.

## Configuration
- Macro: UART_SERIALIZER_HEADER_EN.
- Defined:
  - On accept, bytes_left<=NUM_BYTES+1 and the first byte sent is HEADER_BYTE.
  - The word's bytes follow LSB first. The header occupies a separate pre-stage register selected by a header-pending flag; shift_reg shifts only after data bytes.
- Undefined: no header, and HEADER_BYTE is ignored.

## Test plan
- WORD_WIDTH=32, word 32'h11223344 with a model transmitter (busy high 1 cycle after trigger, for 20 cycles) -> triggers carry 8'h44, 8'h33, 8'h22, 8'h11. Exactly 4 pulses, each one cycle wide; ready returns one cycle after the last busy fall.
- Header macro defined, same word -> 5 triggers: 8'hA5, 8'h44, 8'h33, 8'h22, 8'h11.
- tx_busy_in forced high for 50 cycles when the word is accepted -> no trigger until busy falls; first trigger the cycle busy is low; tx_byte_out=8'h44 throughout.
- Two words 32'hDEADBEEF and 32'h01020304 offered back-to-back with valid held -> second accepted only after the 4th byte of the first completes; 8 bytes in order EF,BE,AD,DE,04,03,02,01.
- rst_n_in pulsed low after the 2nd trigger of 32'hCAFEF00D -> outputs at reset values immediately; no 3rd trigger; a new word 32'h000000FF afterwards sends FF,00,00,00.
- Model transmitter whose busy rises 3 cycles late -> still exactly one trigger per byte, no duplicates.

Source files
------------

// File: rtl/uart_word_serializer.sv
// uart_word_serializer: takes a WORD_WIDTH-bit word over valid/ready and sends it to the
// UART transmitter one byte at a time, LSB byte first. Each byte goes out as a one-cycle
// trigger, and the next byte waits until the transmitter's busy flag has risen and fallen.
// Optional feature: define UART_SERIALIZER_HEADER_EN to send HEADER_BYTE ahead of each word.
module uart_word_serializer #(
  parameter int unsigned WORD_WIDTH  = 64,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid_in,
  output logic                  word_ready_out,
  input  logic                  tx_busy_in,
  output logic [7:0]            tx_byte_out,
  output logic                  tx_trigger_out,
  output logic                  busy_out
);

  localparam int unsigned NumBytes = WORD_WIDTH / 8;
  localparam int unsigned CntW     = $clog2(NumBytes + 2);

  // Reject word widths that are not a whole number of bytes.
  if ((WORD_WIDTH % 8) != 0 || WORD_WIDTH < 8 || $bits(HEADER_BYTE) != 8) begin : g_bad_param
    $error("uart_word_serializer: WORD_WIDTH must be a multiple of 8 and at least 8");
  end

  typedef enum logic [1:0] {StIdle, StSend, StWaitHi, StWaitLo} state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [CntW-1:0]       bytes_left_q, bytes_left_d;
  logic                  accept;
  logic                  byte_done;

  assign accept    = (state_q == StIdle) && word_valid_in;
  assign byte_done = (state_q == StWaitLo) && !tx_busy_in;

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; WAIT_HI covers the transmitter's one-cycle lag in raising busy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (word_valid_in) state_d = StSend;
      StSend:   if (!tx_busy_in) state_d = StWaitHi;
      StWaitHi: if (tx_busy_in) state_d = StWaitLo;
      StWaitLo: begin
        if (!tx_busy_in) begin
          state_d = (bytes_left_q == CntW'(1)) ? StIdle : StSend;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    word_ready_out = (state_q == StIdle);
    busy_out       = (state_q != StIdle);
    tx_trigger_out = (state_q == StSend) && !tx_busy_in;
  end

`ifdef UART_SERIALIZER_HEADER_EN
  logic hdr_pending_q, hdr_pending_d;

  // Header is always the first byte of a word, so it clears on the first completed byte.
  always_comb begin
    hdr_pending_d = hdr_pending_q;
    if (accept) begin
      hdr_pending_d = 1'b1;
    end else if (byte_done) begin
      hdr_pending_d = 1'b0;
    end
  end

  // Header-pending flag register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hdr_pending_q <= 1'b0;
    end else begin
      hdr_pending_q <= hdr_pending_d;
    end
  end

  assign tx_byte_out = hdr_pending_q ? HEADER_BYTE : shift_reg_q[7:0];
`else
  assign tx_byte_out = shift_reg_q[7:0];
`endif

  // Datapath next state: load on accept, step to the next byte when a frame finishes.
  always_comb begin
    shift_reg_d  = shift_reg_q;
    bytes_left_d = bytes_left_q;
    if (accept) begin
      shift_reg_d  = word_in;
`ifdef UART_SERIALIZER_HEADER_EN
      bytes_left_d = CntW'(NumBytes + 1);
`else
      bytes_left_d = CntW'(NumBytes);
`endif
    end else if (byte_done && bytes_left_q != CntW'(1)) begin
      bytes_left_d = bytes_left_q - CntW'(1);
`ifdef UART_SERIALIZER_HEADER_EN
      // The header byte does not consume data, so only shift after a data byte.
      if (!hdr_pending_q) begin
        shift_reg_d = shift_reg_q >> 8;
      end
`else
      shift_reg_d = shift_reg_q >> 8;
`endif
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shift_reg_q  <= '0;
      bytes_left_q <= '0;
    end else begin
      shift_reg_q  <= shift_reg_d;
      bytes_left_q <= bytes_left_d;
    end
  end

endmodule

// File: tb/tb_uart_word_serializer.sv
// Testbench for uart_word_serializer with a 32-bit word and a model transmitter whose busy
// flag rises a programmable number of cycles after a trigger and stays high for 20 cycles.
module tb_uart_word_serializer;

  localparam int unsigned WW = 32;
  localparam int unsigned NB = WW / 8;
`ifdef UART_SERIALIZER_HEADER_EN
  localparam int unsigned NTRIG = NB + 1;
`else
  localparam int unsigned NTRIG = NB;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WW-1:0] word = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          tx_busy;
  logic [7:0]    tx_byte;
  logic          tx_trigger;
  logic          busy;

  uart_word_serializer #(
    .WORD_WIDTH (WW),
    .HEADER_BYTE(8'hA5)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .word_in       (word),
    .word_valid_in (word_valid),
    .word_ready_out(word_ready),
    .tx_busy_in    (tx_busy),
    .tx_byte_out   (tx_byte),
    .tx_trigger_out(tx_trigger),
    .busy_out      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model transmitter.
  int   lag = 1;
  int   dly = 0;
  int   hold = 0;
  logic force_busy = 1'b0;
  logic trig_seen = 1'b0;

  assign tx_busy = (hold != 0) || force_busy;

  always @(posedge clk) begin
    if (hold != 0) hold <= hold - 1;
    if (dly != 0) dly <= dly - 1;
    if (dly == 1) hold <= 20;
    if (trig_seen) begin
      if (lag <= 1) hold <= 20;
      else dly <= lag - 1;
    end
  end

  // Scoreboard monitor: each trigger pops one expected byte.
  logic [7:0] exp_q[$];
  int         trig_count = 0;
  logic [7:0] exp_byte;

  always @(negedge clk) begin
    trig_seen <= rst_n && tx_trigger;
    if (rst_n && tx_trigger) begin
      trig_count++;
      check("no_duplicate_trigger", {31'b0, (hold != 0) || (dly != 0)}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_trigger: got byte %h, required no trigger (t=%0t)",
                 tx_byte, $time);
      end else begin
        exp_byte = exp_q.pop_front();
        check("tx_byte_on_trigger", {24'b0, tx_byte}, {24'b0, exp_byte});
      end
    end
  end

  function automatic logic [7:0] first_byte(input logic [3:0][7:0] e);
`ifdef UART_SERIALIZER_HEADER_EN
    return 8'hA5;
`else
    return e[0];
`endif
  endfunction

  // Offer a word; returns at the negedge of the cycle after acceptance.
  task automatic offer(input logic [WW-1:0] w, input logic [3:0][7:0] e, input bit keep,
                       output int prev_trigs, output logic prev_busy);
    bit done = 1'b0;
    prev_trigs = -1;
    prev_busy  = 1'bx;
    @(negedge clk);
    word = w;
    word_valid = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (word_ready) begin
        prev_trigs = trig_count;
        prev_busy  = tx_busy;
`ifdef UART_SERIALIZER_HEADER_EN
        exp_q.push_back(8'hA5);
`endif
        for (int k = 0; k < 4; k++) exp_q.push_back(e[k]);
        trig_count = 0;
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!keep) word_valid = 1'b0;
    check("word_accepted", {31'b0, done}, 32'd1);
  endtask

  // Wait for the last byte to finish and check ready returns one cycle after busy falls.
  task automatic wait_done();
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
    check("all_bytes_sent", exp_q.size(), 32'd0);
    for (int i = 0; i < 50 && !tx_busy; i++) @(negedge clk);
    check("busy_rose", {31'b0, tx_busy}, 32'd1);
    for (int i = 0; i < 100 && tx_busy; i++) @(negedge clk);
    check("busy_fell", {31'b0, tx_busy}, 32'd0);
    check("ready_low_at_busy_fall", {31'b0, word_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_busy_fall", {31'b0, word_ready}, 32'd1);
    check("busy_out_after_word", {31'b0, busy}, 32'd0);
    check("trigger_count", trig_count, NTRIG);
  endtask

  typedef struct {
    logic [31:0]     word;
    int              lag;
    int              stall;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pt;
    logic pb;

    vecs[0] = '{32'h11223344, 1, 0,  {8'h11, 8'h22, 8'h33, 8'h44}};
    vecs[1] = '{32'h11223344, 1, 50, {8'h11, 8'h22, 8'h33, 8'h44}};
    vecs[2] = '{32'hA1B2C3D4, 3, 0,  {8'hA1, 8'hB2, 8'hC3, 8'hD4}};
    vecs[3] = '{32'h5A0080FF, 2, 0,  {8'h5A, 8'h00, 8'h80, 8'hFF}};

    // Reset values.
    @(negedge clk);
    check("rst_ready", {31'b0, word_ready}, 32'd1);
    check("rst_trigger", {31'b0, tx_trigger}, 32'd0);
    check("rst_byte", {24'b0, tx_byte}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven words.
    for (int v = 0; v < 4; v++) begin
      lag = vecs[v].lag;
      force_busy = (vecs[v].stall != 0);
      offer(vecs[v].word, vecs[v].exp, 1'b0, pt, pb);
      if (vecs[v].stall != 0) begin
        for (int k = 0; k < vecs[v].stall; k++) begin
          check("stall_no_trigger", {31'b0, tx_trigger}, 32'd0);
          check("stall_byte_held", {24'b0, tx_byte}, {24'b0, first_byte(vecs[v].exp)});
          @(negedge clk);
        end
        @(posedge clk);
        #1 force_busy = 1'b0;
        @(negedge clk);
        check("trigger_when_busy_low", {31'b0, tx_trigger}, 32'd1);
      end else begin
        check("first_trigger_next_cycle", {31'b0, tx_trigger}, 32'd1);
      end
      wait_done();
    end

    // Back-to-back words with valid held; word_in changes while the first is in flight.
    lag = 1;
    offer(32'hDEADBEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b1, pt, pb);
    check("b2b_first_trigger", {31'b0, tx_trigger}, 32'd1);
    offer(32'h01020304, {8'h01, 8'h02, 8'h03, 8'h04}, 1'b0, pt, pb);
    check("b2b_first_word_done", pt, NTRIG);
    check("b2b_tx_idle_at_accept", {31'b0, pb}, 32'd0);
    check("b2b_second_trigger", {31'b0, tx_trigger}, 32'd1);
    wait_done();

    // Reset mid-word after the second trigger.
    offer(32'hCAFEF00D, {8'hCA, 8'hFE, 8'hF0, 8'h0D}, 1'b0, pt, pb);
    for (int i = 0; i < 200 && trig_count < 2; i++) @(negedge clk);
    check("two_triggers_before_reset", trig_count, 32'd2);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, word_ready}, 32'd1);
    check("midrst_trigger", {31'b0, tx_trigger}, 32'd0);
    check("midrst_byte", {24'b0, tx_byte}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) @(negedge clk);
    check("no_trigger_after_reset", trig_count, 32'd2);
    offer(32'h000000FF, {8'h00, 8'h00, 8'h00, 8'hFF}, 1'b0, pt, pb);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
